// File: rtl/noc_output_port_arbiter_pkg.sv
// Shared router parameters and arbiter state type for noc_output_port_arbiter.
// Optional build macro used by the top: NOC_ARB_STATS_EN.
package Noc_parameters;

  localparam int unsigned Noc_VC_Channel    = 2;
  localparam int unsigned Noc_VC_Fifo_Depth = 4;

  // Encodings kept bit-identical to the legacy state constants.
  localparam logic [0:0] ARB_IDLE_ENC   = 1'b0;
  localparam logic [0:0] ARB_LOCKED_ENC = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE   = ARB_IDLE_ENC,
    ARB_LOCKED = ARB_LOCKED_ENC
  } arb_state_t;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/noc_output_port_arbiter_if.sv
// Request/grant/credit bundle between input-block senders, the output arbiter and the link.
interface noc_output_port_arbiter_if #(
  parameter int unsigned NPORT = 5,
  parameter int unsigned VC_W  = 1
);
  logic [NPORT-1:0]      req_valid;
  logic [NPORT*VC_W-1:0] req_vc;
  logic [NPORT-1:0]      req_head;
  logic [NPORT-1:0]      req_tail;
  logic [NPORT-1:0]      gnt;
  logic                  out_valid;
  logic [VC_W-1:0]       out_vc;
  logic                  credit_valid;
  logic [VC_W-1:0]       credit_vc;

  modport master (
    output req_valid, req_vc, req_head, req_tail, credit_valid, credit_vc,
    input  gnt, out_valid, out_vc
  );

  modport slave (
    input  req_valid, req_vc, req_head, req_tail, credit_valid, credit_vc,
    output gnt, out_valid, out_vc
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, one-hot result.
module noc_rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_port_arbiter.sv
// Per-output-port switch arbiter with wormhole lock and per-VC downstream credits.
// Define NOC_ARB_STATS_EN to add per-port grant counters (stat_gnt_cnt, stat_clr).
module noc_output_port_arbiter
  import Noc_parameters::*;
#(
  parameter int unsigned NPORT        = 5,
  parameter int unsigned CHANNELS     = Noc_VC_Channel,
  parameter int unsigned CREDIT_DEPTH = Noc_VC_Fifo_Depth,
  parameter int unsigned VC_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   noc_clk,
  input  logic                   noc_rst,
  noc_output_port_arbiter_if.slave bus,
  output logic                   locked,
  output logic [2:0]             lock_port,
  output logic [1:0]             err
`ifdef NOC_ARB_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [NPORT-1:0][15:0] stat_gnt_cnt
`endif
);

  localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);
  localparam int unsigned PW = 3;
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);

  arb_state_t      state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   lock_port_q;
  logic [VC_W-1:0] lock_vc_q;
  logic [CW-1:0]   credits_q [CHANNELS];
  logic [1:0]      err_q;

  logic [VC_W-1:0]     vc_of [NPORT];
  logic [NPORT-1:0]    eligible;
  logic [NPORT-1:0]    cand;
  logic [NPORT-1:0]    gnt_c;
  logic [PW-1:0]       gnt_idx;
  logic                out_valid_c;
  logic [VC_W-1:0]     out_vc_c;
  logic                proto_err;
  logic                overflow;
  logic [CHANNELS-1:0] credit_inc;
  logic [CHANNELS-1:0] credit_dec;

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      vc_of[i]    = bus.req_vc[i*VC_W +: VC_W];
      eligible[i] = bus.req_valid[i] && (32'(vc_of[i]) < CHANNELS) &&
                    (credits_q[vc_of[i]] != '0);
    end
  end

  // While locked only the owner can be a candidate, so the round-robin
  // picker degenerates to a pass-through and is shared by both states.
  always_comb begin
    cand      = '0;
    proto_err = 1'b0;
    if (state_q == ARB_IDLE) begin
      cand      = eligible & bus.req_head;
      proto_err = |(bus.req_valid & ~bus.req_head);
    end else if (bus.req_valid[lock_port_q]) begin
      if (bus.req_head[lock_port_q] || (vc_of[lock_port_q] != lock_vc_q))
        proto_err = 1'b1;
      else
        cand[lock_port_q] = eligible[lock_port_q];
    end
  end

  noc_rr_arbiter #(
    .N     (NPORT),
    .PTR_W (PW)
  ) u_rr (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (gnt_c)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NPORT; i++)
      if (gnt_c[i]) gnt_idx = PW'(i);
  end

  assign out_valid_c   = |gnt_c;
  assign out_vc_c      = out_valid_c ? vc_of[gnt_idx] : '0;
  assign bus.gnt       = gnt_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_vc    = out_vc_c;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      lock_port_q <= '0;
      lock_vc_q   <= '0;
    end else if (out_valid_c) begin
      if (state_q == ARB_IDLE) begin
        if (bus.req_tail[gnt_idx]) begin
          rr_ptr_q <= wrap_inc(gnt_idx, NPORT);
        end else begin
          state_q     <= ARB_LOCKED;
          lock_port_q <= gnt_idx;
          lock_vc_q   <= vc_of[gnt_idx];
        end
      end else if (bus.req_tail[gnt_idx]) begin
        state_q     <= ARB_IDLE;
        rr_ptr_q    <= wrap_inc(lock_port_q, NPORT);
        lock_port_q <= '0;
      end
    end
  end

  always_comb begin
    overflow = 1'b0;
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      credit_dec[v] = out_valid_c && (32'(out_vc_c) == v);
      credit_inc[v] = bus.credit_valid && (32'(bus.credit_vc) == v);
      if (credit_inc[v] && !credit_dec[v] && (credits_q[v] == CREDIT_FULL))
        overflow = 1'b1;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int unsigned v = 0; v < CHANNELS; v++)
        credits_q[v] <= CREDIT_FULL;
    end else begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        if (credit_inc[v] && !credit_dec[v] && (credits_q[v] != CREDIT_FULL))
          credits_q[v] <= credits_q[v] + 1'b1;
        else if (credit_dec[v] && !credit_inc[v])
          credits_q[v] <= credits_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) err_q <= '0;
    else         err_q <= err_q | {proto_err, overflow};
  end

  assign err       = err_q;
  assign locked    = (state_q == ARB_LOCKED);
  assign lock_port = locked ? lock_port_q : '0;

`ifdef NOC_ARB_STATS_EN
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      stat_gnt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (stat_clr)
          stat_gnt_cnt[i] <= '0;
        else if (gnt_c[i] && (stat_gnt_cnt[i] != '1))
          stat_gnt_cnt[i] <= stat_gnt_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Self-checking bench: directed scenarios plus random wormhole traffic against a queue-free reference model.
module tb_noc_output_port_arbiter;
  import Noc_parameters::*;

  localparam int NP    = 5;
  localparam int CH    = Noc_VC_Channel;
  localparam int DEPTH = Noc_VC_Fifo_Depth;
  localparam int VW    = (CH > 1) ? $clog2(CH) : 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked;
  logic [2:0] lock_port;
  logic [1:0] err;
`ifdef NOC_ARB_STATS_EN
  logic                 stat_clr = 1'b0;
  logic [NP-1:0][15:0]  stat_gnt_cnt;
`endif

  noc_output_port_arbiter_if #(.NPORT(NP), .VC_W(VW)) bus ();

  noc_output_port_arbiter #(
    .NPORT        (NP),
    .CHANNELS     (CH),
    .CREDIT_DEPTH (DEPTH),
    .VC_W         (VW)
  ) dut (
    .noc_clk   (clk),
    .noc_rst   (rst),
    .bus       (bus),
    .locked    (locked),
    .lock_port (lock_port),
    .err       (err)
`ifdef NOC_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_gnt_cnt (stat_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus
  logic [NP-1:0] valid, head, tail;
  int            vc [NP];
  logic          cv;
  int            cvc;

  // reference model
  bit       m_locked;
  int       m_owner, m_vc, m_ptr;
  int       m_cred [CH];
  bit [1:0] m_err;
  int       last_w;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    valid = '0; head = '0; tail = '0; cv = 1'b0; cvc = 0;
    for (int i = 0; i < NP; i++) vc[i] = 0;
  endtask

  task automatic apply();
    bus.req_valid    = valid;
    bus.req_head     = head;
    bus.req_tail     = tail;
    for (int i = 0; i < NP; i++) bus.req_vc[i*VW +: VW] = VW'(vc[i]);
    bus.credit_valid = cv;
    bus.credit_vc    = VW'(cvc);
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_vc = 0; m_ptr = 0; m_err = 0;
    for (int v = 0; v < CH; v++) m_cred[v] = DEPTH;
  endtask

  function automatic int model_pick();
    if (!m_locked) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (valid[p] && head[p] && m_cred[vc[p]] > 0) return p;
      end
      return -1;
    end
    if (valid[m_owner] && !head[m_owner] && vc[m_owner] == m_vc && m_cred[m_vc] > 0)
      return m_owner;
    return -1;
  endfunction

  // Drive current stimulus, compare all outputs, then advance the model past the coming edge.
  task automatic step();
    int w;
    apply();
    #1;
    w = model_pick();
    check_val("gnt",       32'(bus.gnt),       (w >= 0) ? (32'd1 << w) : 32'd0);
    check_val("out_valid", 32'(bus.out_valid), (w >= 0) ? 32'd1 : 32'd0);
    check_val("out_vc",    32'(bus.out_vc),    (w >= 0) ? 32'(vc[w]) : 32'd0);
    check_val("locked",    32'(locked),        32'(m_locked));
    check_val("lock_port", 32'(lock_port),     m_locked ? 32'(m_owner) : 32'd0);
    check_val("err",       32'(err),           32'(m_err));
    if (!m_locked && |(valid & ~head)) m_err[1] = 1'b1;
    if (m_locked && valid[m_owner] && (head[m_owner] || vc[m_owner] != m_vc)) m_err[1] = 1'b1;
    for (int v = 0; v < CH; v++) begin
      bit inc, dec;
      inc = cv && (cvc == v);
      dec = (w >= 0) && (vc[w] == v);
      if (inc && !dec) begin
        if (m_cred[v] == DEPTH) m_err[0] = 1'b1;
        else m_cred[v]++;
      end else if (dec && !inc) m_cred[v]--;
    end
    if (w >= 0) begin
      if (!m_locked) begin
        if (tail[w]) m_ptr = (w + 1) % NP;
        else begin m_locked = 1; m_owner = w; m_vc = vc[w]; end
      end else if (tail[w]) begin
        m_locked = 0; m_ptr = (m_owner + 1) % NP;
      end
    end
    last_w = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gnt"},       32'(bus.gnt),       32'd0);
    check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_out_vc"},    32'(bus.out_vc),    32'd0);
    check_val({tag, "_locked"},    32'(locked),        32'd0);
    check_val({tag, "_lock_port"}, 32'(lock_port),     32'd0);
    check_val({tag, "_err"},       32'(err),           32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    apply();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int act [NP];
  int len [NP];
  int pos [NP];
  int pvc [NP];

  initial begin
    logic [31:0] exp_g;
    clear_inputs();
    apply();
    model_reset();
    do_reset();

    // two single-flit requesters alternate until VC0 credits run dry
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      valid = 5'b01010; head = 5'b01010; tail = 5'b01010;
      step();
      exp_g = (c >= 4) ? 32'd0 : ((c % 2 == 0) ? 32'b00010 : 32'b01000);
      check_val("t1_gnt", 32'(bus.gnt), exp_g);
    end

    // wormhole: port 2 owns the output for five flits while port 0 waits
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      vc[2] = 1;
      if (c == 0) begin valid = 5'b00100; head = 5'b00100; end
      else if (c < 5) begin valid = 5'b00101; head = 5'b00001; tail = (c == 4) ? 5'b00100 : 5'b00000; end
      else begin valid = 5'b00001; head = 5'b00001; tail = 5'b00001; end
      if (c < 5) begin cv = 1'b1; cvc = 1; end
      step();
      check_val("t2_gnt", 32'(bus.gnt), (c < 5) ? 32'b00100 : 32'b00001);
    end
    check_val("t2_err", 32'(err), 32'd0);

    // credit exhaustion stalls the owner; one returned credit releases one flit
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      clear_inputs();
      valid = 5'b00001;
      head  = (c == 0) ? 5'b00001 : 5'b00000;
      if (c == 6) begin cv = 1'b1; cvc = 0; end
      step();
      check_val("t3_gnt", 32'(bus.gnt), (c < 4 || c == 7) ? 32'd1 : 32'd0);
      if (c > 0) check_val("t3_locked", 32'(locked), 32'd1);
    end

    // simultaneous grant and return on VC1 is neutral; a return at full overflows
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) begin valid = 5'b00001; head = 5'b00001; tail = 5'b00001; vc[0] = 1; end
      if (c < 2) begin cv = 1'b1; cvc = 1; end
      step();
      check_val("t4_err", 32'(err), (c == 2) ? 32'd1 : 32'd0);
    end

    // asynchronous reset in the middle of a packet owned by port 4
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clear_inputs();
      valid = 5'b10000;
      head  = (c == 0) ? 5'b10000 : 5'b00000;
      step();
    end
    check_val("t5_lock_port", 32'(lock_port), 32'd4);
    rst = 1'b1;
    #1;
    check_val("t5_locked", 32'(locked), 32'd0);
    check_val("t5_gnt",    32'(bus.gnt), 32'd0);
    model_reset();
    clear_inputs();
    apply();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      valid = 5'b00001; head = 5'b00001; tail = 5'b00001;
      step();
      check_val("t5_credit_gnt", 32'(bus.gnt), (c < DEPTH) ? 32'd1 : 32'd0);
    end

    // body flit while idle: no grant, sticky protocol error
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) valid = 5'b00010;
      step();
      check_val("t6_gnt", 32'(bus.gnt), 32'd0);
      check_val("t6_err", 32'(err), (c == 0) ? 32'd0 : 32'd2);
    end
    do_reset();

    // random well-formed wormhole traffic with credit returns
    for (int i = 0; i < NP; i++) begin act[i] = 0; len[i] = 1; pos[i] = 0; pvc[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      int v;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < NP; i++) begin
        if (act[i] == 0 && $urandom_range(3) == 0) begin
          act[i] = 1; len[i] = $urandom_range(4, 1); pos[i] = 0; pvc[i] = $urandom_range(CH - 1);
        end
        valid[i] = (act[i] != 0) && ($urandom_range(4) != 0);
        head[i]  = (pos[i] == 0);
        tail[i]  = (pos[i] == len[i] - 1);
        vc[i]    = pvc[i];
      end
      v = $urandom_range(CH - 1);
      if (m_cred[v] < DEPTH && $urandom_range(1) == 0) begin cv = 1'b1; cvc = v; end
      step();
      if (last_w >= 0) begin
        pos[last_w]++;
        if (pos[last_w] == len[last_w]) act[last_w] = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
